// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding, the PC step and the default reset PC.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INC           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_skid_buffer.sv
// Single-entry {pc, instruction} holding register used when decode is
// frozen at the moment memory returns a word.
module if_skid_buffer #(
    parameter int BIT_NUMBER = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  unload,
    input  logic                  clear,
    input  logic [BIT_NUMBER-1:0] load_pc,
    input  logic [BIT_NUMBER-1:0] load_instr,
    output logic                  full,
    output logic [BIT_NUMBER-1:0] pc,
    output logic [BIT_NUMBER-1:0] instr
);

    logic                  full_q,  full_d;
    logic [BIT_NUMBER-1:0] pc_q,    pc_d;
    logic [BIT_NUMBER-1:0] instr_q, instr_d;

    always_comb begin
        // NOTE: every variable is given a default first so no path through always_comb infers a latch.
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (unload) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d  = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end
        // A branch flush wins over a simultaneous capture.
        if (clear) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values together.
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full  = full_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over req/ack and feeds
// decode with {pc, instruction, valid}. Define FETCH_PERF_CNT_EN for counters.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                    BIT_NUMBER = 32,
    parameter logic [BIT_NUMBER-1:0] RESET_PC   = BIT_NUMBER'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [BIT_NUMBER-1:0] branch_addr,
    output logic                  mem_req,
    output logic [BIT_NUMBER-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [BIT_NUMBER-1:0] mem_rdata,
    output logic [BIT_NUMBER-1:0] pc,
    output logic [BIT_NUMBER-1:0] instruction,
    output logic                  valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count
`endif
);

    fetch_state_e          state_q,  state_d;
    logic [BIT_NUMBER-1:0] pc_reg_q, pc_reg_d;
    logic [BIT_NUMBER-1:0] addr_q,   addr_d;
    logic [BIT_NUMBER-1:0] pc_q,     pc_d;
    logic [BIT_NUMBER-1:0] instr_q,  instr_d;
    logic                  valid_q,  valid_d;
    logic [BIT_NUMBER-1:0] pc_next;

    logic                  ack_seen;
    logic                  slot_free;
    logic                  consumed;

    logic                  skid_load, skid_unload, skid_clear, skid_full;
    logic [BIT_NUMBER-1:0] skid_pc, skid_instr;

    // The request line stays low while reset is held even though state is REQ.
    assign mem_req   = rst && (state_q != HOLD);
    assign mem_addr  = addr_q;
    assign ack_seen  = mem_req && mem_ack;
    assign slot_free = !valid_q || !freeze;
    assign consumed  = valid_q && !freeze;
    assign pc_next   = pc_reg_q + BIT_NUMBER'(PC_INC);

    if_skid_buffer #(
        .BIT_NUMBER (BIT_NUMBER)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_pc    (pc_next),
        .load_instr (mem_rdata),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_comb begin
        state_d     = state_q;
        pc_reg_d    = pc_reg_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q && !consumed;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (branch_taken) begin
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            pc_reg_d   = branch_addr;
            unique case (state_q)
                REQ:     state_d = ack_seen ? REQ : DROP;
                HOLD:    state_d = REQ;
                DROP:    state_d = ack_seen ? REQ : DROP;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (ack_seen) begin
                        pc_reg_d = pc_next;
                        if (slot_free) begin
                            pc_d    = pc_next;
                            instr_d = mem_rdata;
                            valid_d = 1'b1;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!freeze && skid_full) begin
                        pc_d        = skid_pc;
                        instr_d     = skid_instr;
                        valid_d     = 1'b1;
                        skid_unload = 1'b1;
                        state_d     = REQ;
                    end
                end
                DROP: begin
                    if (ack_seen) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end

        // While a dropped request is outstanding the bus address must not move.
        addr_d = (state_d == DROP) ? addr_q : pc_reg_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= REQ;
            pc_reg_q <= RESET_PC;
            addr_q   <= RESET_PC;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_reg_q <= pc_reg_d;
            addr_q   <= addr_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    assign pc          = pc_q;
    assign instruction = instr_q;
    assign valid       = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + (consumed ? 32'd1 : 32'd0);
        stall_count_d = stall_count_q + ((valid_q && freeze) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed walk through the fetch scenarios, then a
// randomized run scored against an address-stream model of the fetch stage.
module tb_if_fetch_unit;

    logic        clk          = 1'b0;
    logic        rst          = 1'b0;
    logic        freeze       = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr  = 32'h0;
    logic        mem_ack      = 1'b0;
    logic [31:0] mem_rdata    = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Expected delivery stream: pc (= fetch address + 4) and instruction word.
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_in_q[$];
    logic [31:0] gen_addr;

    logic        mon_en    = 1'b0;
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          idle      = 0;
    int          max_idle  = 0;
    int          n_fetch   = 0;
    int          n_stall   = 0;

    if_fetch_unit #(
        .BIT_NUMBER (32),
        .RESET_PC   (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .pc           (pc),
        .instruction  (instruction),
        .valid        (valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hE5A1_3C07;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, return 1 time unit after it.
    task automatic cyc(input logic ack, input logic frz, input logic br, input logic [31:0] baddr);
        mem_ack      = ack;
        mem_rdata    = (ack && mem_req) ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        freeze       = frz;
        branch_taken = br;
        branch_addr  = baddr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
    endtask

    // Monitor: pops the scoreboard on every delivery and checks the bus protocol.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (prev_req && !prev_ack) begin
                check("req_held", 32'(mem_req), 32'd1);
                check("addr_stable", mem_addr, prev_addr);
            end
            if (valid && !freeze) begin
                if (exp_pc_q.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    check("sb_pc", pc, exp_pc_q.pop_front());
                    check("sb_instr", instruction, exp_in_q.pop_front());
                end
                n_fetch++;
                idle = 0;
            end else begin
                idle++;
                if (idle > max_idle) max_idle = idle;
            end
            if (valid && freeze) n_stall++;
            prev_req  = mem_req;
            prev_ack  = mem_ack;
            prev_addr = mem_addr;
        end else begin
            prev_req = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] baddr;
        logic        br;

        // Reset state, with the clock running.
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        rst = 1'b1;
        #1;
        check("rel_mem_req", 32'(mem_req), 32'd1);
        check("rel_mem_addr", mem_addr, 32'h0);

        // Back-to-back acks.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("b2b_pc4", pc, 32'h4);
        check("b2b_instr0", instruction, mem_word(32'h0));
        check("b2b_valid", 32'(valid), 32'd1);
        check("b2b_addr4", mem_addr, 32'h4);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("b2b_pc8", pc, 32'h8);
        check("b2b_addr8", mem_addr, 32'h8);

        // Ack for 0x8 under freeze: output holds, word goes to the skid.
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        check("frz_pc_hold", pc, 32'h8);
        check("frz_mem_req", 32'(mem_req), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("frz_pc_hold3", pc, 32'h8);
        check("frz_valid", 32'(valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("unfrz_pc12", pc, 32'hC);
        check("unfrz_instr8", instruction, mem_word(32'h8));
        check("unfrz_mem_addr", mem_addr, 32'hC);
        check("unfrz_mem_req", 32'(mem_req), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("resume_pc16", pc, 32'h10);

        // Branch while the request for 0x10 is outstanding.
        cyc(1'b0, 1'b0, 1'b1, 32'h100);
        check("br_valid0", 32'(valid), 32'd0);
        check("br_old_addr", mem_addr, 32'h10);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("drop_valid0", 32'(valid), 32'd0);
        check("drop_new_addr", mem_addr, 32'h100);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("br_pc104", pc, 32'h104);
        check("br_instr100", instruction, mem_word(32'h100));

        // Branch coincident with ack and freeze: no skid capture.
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        check("brack_valid0", 32'(valid), 32'd0);
        check("brack_mem_req", 32'(mem_req), 32'd1);
        check("brack_addr", mem_addr, 32'h200);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("brack_pc204", pc, 32'h204);

        // Reset asserted in HOLD.
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        check("hold_mem_req0", 32'(mem_req), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_pc", pc, 32'h0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rerel_addr", mem_addr, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("rerel_pc4", pc, 32'h4);

        // Randomized run against the stream model.
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_pc_q.delete();
        exp_in_q.delete();
        gen_addr = 32'h0;
        rst      = 1'b1;
        mon_en   = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            // A branch in the cycle just finished restarts the stream at its target.
            if (branch_taken) begin
                exp_pc_q.delete();
                exp_in_q.delete();
                gen_addr = branch_addr;
            end
            while (exp_pc_q.size() < 8) begin
                exp_pc_q.push_back(gen_addr + 32'd4);
                exp_in_q.push_back(mem_word(gen_addr));
                gen_addr = gen_addr + 32'd4;
            end
            r  = $urandom;
            br = ($urandom_range(99) < 3);
            if ($urandom_range(3) == 0) baddr = 32'hFFFF_FFF0 | {28'h0, r[3:2], 2'b00};
            else                        baddr = {r[31:2], 2'b00};
            cyc(1'($urandom_range(1)), ($urandom_range(9) < 3), br, baddr);
        end
        idle_inputs();
        mon_en = 1'b0;
        check("liveness", 32'(max_idle < 64), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, 32'(n_fetch));
        check("stall_count", stall_count, 32'(n_stall));
`endif
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the ARM pipeline: the producer end of the pc/instruction interface that the decode stage consumes.
- Owns the PC register and issues word fetches to instruction memory over a req/ack handshake.
- Presents {pc, instruction, valid} to decode and honours decode freeze (hazard stall) and branch redirect (flush).

Parameters:
- BIT_NUMBER, 32, datapath/address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- freeze  input  1  decode cannot accept; a presented instruction is consumed when valid=1 and freeze=0.
- branch_taken  input  1  redirect request from execute.
- branch_addr  input  BIT_NUMBER  redirect target, word aligned.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  BIT_NUMBER  fetch address.
- mem_ack  input  1  memory response strobe, one cycle.
- mem_rdata  input  BIT_NUMBER  instruction word, valid only while mem_ack=1.
- pc  output  BIT_NUMBER  fetched address + 4, ARM convention.
- instruction  output  BIT_NUMBER  fetched word.
- valid  output  1  pc/instruction hold a live instruction.

Behaviour:
- Reset (rst=0, async):
  - pc_reg = RESET_PC; state = REQ.
  - valid = 0; pc = 0; instruction = 0.
  - Skid buffer empty.
  - mem_req is 0 while reset is asserted and asserts in the first cycle after release.
- Handshake: mem_req stays high until a cycle with mem_ack=1; mem_addr is stable while mem_req=1; mem_ack with mem_req=0 is ignored.
- Output slot is free when valid=0 or freeze=0.
- States:
  - REQ: mem_req=1, mem_addr=pc_reg.
    - On ack with slot free: load pc=pc_reg+4, instruction=mem_rdata, valid=1; pc_reg += 4; stay REQ. Back-to-back acks give one instruction per cycle.
    - On ack with slot busy: capture {pc_reg+4, mem_rdata} in the skid buffer; pc_reg += 4; go to HOLD.
  - HOLD: mem_req=0. When freeze=0, move the skid contents to the outputs (valid=1) and go to REQ.
  - DROP: mem_req=1 with the old address. On ack, discard the data and go to REQ using the redirected pc_reg.
- Consumption without a new load (slot consumed, no ack that cycle): valid goes to 0 next cycle.
- Branch (branch_taken=1) has priority over freeze and ack:
  - Next cycle: valid=0 and the skid buffer is cleared; pc_reg = branch_addr.
  - In REQ with no ack that cycle: request is outstanding, go to DROP.
  - In REQ with ack the same cycle: data discarded, stay REQ.
  - In HOLD: go to REQ.
  - In DROP: target updated, stay DROP.
- pc_reg wraps modulo 2^BIT_NUMBER; no alignment check.
- Latency: request to valid output is 1 cycle after ack.
- No instruction is duplicated or lost except those flushed by a branch.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_count and stall_count (32-bit each, reset 0, wrap).
  - fetch_count increments on each instruction delivered to decode (valid=1 and freeze=0).
  - stall_count increments on each cycle with valid=1 and freeze=1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - fetch state enum {REQ, HOLD, DROP}
  - PC_INC=4
  - RESET_PC default
- One sub-module, if_skid_buffer: a single-entry {pc, instruction} register with load/unload/clear.

Test Plan:
- Reset release, mem_ack every cycle, freeze=0 -> mem_addr 0,4,8; outputs pc=4,8,12 on consecutive cycles, valid held 1.
- freeze=1 for 3 cycles while ack arrives for addr 8 -> outputs hold pc=8; skid holds pc=12; mem_req=0. On freeze=0, pc=12 next cycle, then fetch resumes at 12.
- branch_taken with branch_addr=0x100 while request for 0x10 is outstanding -> valid=0 next cycle; 0x10 data discarded on its ack; next mem_addr=0x100; output pc=0x104.
- branch_taken coincident with ack and freeze=1 -> no skid capture, valid=0, next mem_addr=branch_addr.
- rst asserted mid-HOLD -> valid=0, mem_req=0 immediately; after release fetch restarts at RESET_PC.
- FETCH_PERF_CNT_EN: 5 delivered instructions plus 2 freeze cycles -> fetch_count=5, stall_count=2.
